// File: rtl/ahb_apb_ctrl.sv
// AHB-Lite to APB bridge core for four APB slaves with a one-entry pipelined request buffer.
module ahb_apb_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter logic [3:0]  BASE_NIB = 4'h8
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              Hwrite,
  input  logic              Hreadyin,
  input  logic [1:0]        Htrans,
  input  logic [31:0]       Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Prdata,
  output logic [3:0]        Pselx,
  output logic [31:0]       Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Pwrite,
  output logic              Penable,
  output logic              Hreadyout,
  output logic [DATA_W-1:0] Hrdata,
  output logic [1:0]        Hresp
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned NSLV   = 4;

  typedef enum logic [1:0] {S_IDLE, S_WWAIT, S_SETUP, S_ACCESS} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic                pend_write_q, pend_write_d;
  logic                pend_v_q, pend_v_d;
  logic [NSLV-1:0]     pselx_q, pselx_d;
  logic                penable_q, penable_d;
  logic                hready_q, hready_d;
  logic                valid;
  logic                unused_htrans0;

  assign unused_htrans0 = Htrans[0];

  // A new AHB request is taken only in our region while we are ready.
  assign valid = Hreadyin & Htrans[1] & (Haddr[31:28] == BASE_NIB) & hready_q;

  // Next state, transfer latches and next registered APB/AHB outputs.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    pend_addr_d  = pend_addr_q;
    pend_write_d = pend_write_q;
    pend_v_d     = pend_v_q;

    unique case (state_q)
      S_IDLE: begin
        if (valid) begin
          addr_d  = Haddr;
          write_d = Hwrite;
          state_d = Hwrite ? S_WWAIT : S_SETUP;
        end
      end
      S_WWAIT: begin
        wdata_d = Hwdata;
        if (valid) begin
          pend_addr_d  = Haddr;
          pend_write_d = Hwrite;
          pend_v_d     = 1'b1;
        end
        state_d = S_SETUP;
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (pend_v_q) begin
          addr_d   = pend_addr_q;
          write_d  = pend_write_q;
          pend_v_d = 1'b0;
          state_d  = pend_write_q ? S_WWAIT : S_SETUP;
        end else if (valid) begin
          addr_d  = Haddr;
          write_d = Hwrite;
          state_d = Hwrite ? S_WWAIT : S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    pselx_d   = ((state_d == S_SETUP) || (state_d == S_ACCESS))
              ? (NSLV'(1) << addr_d[27:26]) : '0;
    penable_d = (state_d == S_ACCESS);
    hready_d  = !((state_d == S_SETUP) || ((state_d == S_ACCESS) && pend_v_d));
  end

  // State and output registers; reset discards any in-flight or pending transfer.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      pend_addr_q  <= '0;
      pend_write_q <= 1'b0;
      pend_v_q     <= 1'b0;
      pselx_q      <= '0;
      penable_q    <= 1'b0;
      hready_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      pend_addr_q  <= pend_addr_d;
      pend_write_q <= pend_write_d;
      pend_v_q     <= pend_v_d;
      pselx_q      <= pselx_d;
      penable_q    <= penable_d;
      hready_q     <= hready_d;
    end
  end

  assign Pselx     = pselx_q;
  assign Paddr     = addr_q;
  assign Pwdata    = wdata_q;
  assign Pwrite    = write_q;
  assign Penable   = penable_q;
  assign Hreadyout = hready_q;
  assign Hrdata    = Prdata;
  assign Hresp     = 2'b00;

endmodule

// File: tb/tb_ahb_apb_ctrl.sv
// Bench for ahb_apb_ctrl: per-cycle timeline model of expected APB/AHB activity.
module tb_ahb_apb_ctrl;

  localparam int unsigned DW = 32;
  localparam int RING = 16;

  logic          Hclk = 1'b0;
  logic          Hreset;
  logic          Hwrite, Hreadyin;
  logic [1:0]    Htrans;
  logic [31:0]   Haddr;
  logic [DW-1:0] Hwdata, Prdata;
  logic [3:0]    Pselx;
  logic [31:0]   Paddr;
  logic [DW-1:0] Pwdata, Hrdata;
  logic          Pwrite, Penable, Hreadyout;
  logic [1:0]    Hresp;

  ahb_apb_ctrl #(.DATA_W(DW), .BASE_NIB(4'h8)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
    .Pselx(Pselx), .Paddr(Paddr), .Pwdata(Pwdata), .Pwrite(Pwrite),
    .Penable(Penable), .Hreadyout(Hreadyout), .Hrdata(Hrdata), .Hresp(Hresp)
  );

  always #5 Hclk = ~Hclk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Expected activity per future cycle (ring indexed by cycle number).
  logic [3:0]  e_psel  [RING];
  logic        e_pen   [RING];
  logic [31:0] e_addr  [RING];
  logic        e_wr    [RING];
  logic [31:0] e_wd    [RING];
  logic        e_hrdy  [RING];
  logic        e_wphase[RING];

  // Values sampled from the DUT in the most recent cycle.
  logic [3:0]  s_psel;
  logic        s_pen, s_hrdy, s_pwr;
  logic [31:0] s_paddr, s_pwd, s_hrd;

  function automatic void clear_slot(input int i);
    e_psel[i] = 4'b0; e_pen[i] = 1'b0; e_addr[i] = 32'h0; e_wr[i] = 1'b0;
    e_wd[i] = 32'h0; e_hrdy[i] = 1'b1; e_wphase[i] = 1'b0;
  endfunction

  function automatic void clear_all();
    for (int k = 0; k < RING; k++) clear_slot(k);
  endfunction

  // A transfer whose address takes effect in cycle s: writes spend s+1 taking data.
  function automatic void sched(input int s, input logic [31:0] a, input logic w);
    logic [3:0] sel;
    int b;
    sel = 4'b0001 << a[27:26];
    b = w ? s + 1 : s;
    if (w) e_wphase[(s + 1) % RING] = 1'b1;
    e_psel[(b + 1) % RING] = sel; e_addr[(b + 1) % RING] = a;
    e_wr[(b + 1) % RING] = w;     e_hrdy[(b + 1) % RING] = 1'b0;
    e_psel[(b + 2) % RING] = sel; e_addr[(b + 2) % RING] = a;
    e_wr[(b + 2) % RING] = w;     e_pen[(b + 2) % RING] = 1'b1;
    e_hrdy[(b + 2) % RING] = 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // One bus cycle: compare against the model, drive inputs, then advance the model.
  task automatic cycle(input logic rdyin, input logic [1:0] trans, input logic [31:0] addr,
                       input logic wr, input logic [31:0] wd, input logic [31:0] prd);
    int i;
    logic acc;
    i = cyc % RING;
    @(negedge Hclk);
    s_psel = Pselx; s_pen = Penable; s_hrdy = Hreadyout; s_pwr = Pwrite;
    s_paddr = Paddr; s_pwd = Pwdata;
    chk("hreadyout", 32'(s_hrdy), 32'(e_hrdy[i]));
    chk("hresp", 32'(Hresp), 32'h0);
    chk("pselx", 32'(s_psel), 32'(e_psel[i]));
    chk("penable", 32'(s_pen), 32'(e_pen[i]));
    if (e_psel[i] != 4'b0) begin
      chk("paddr", s_paddr, e_addr[i]);
      chk("pwrite", 32'(s_pwr), 32'(e_wr[i]));
      if (e_wr[i]) chk("pwdata", s_pwd, e_wd[i]);
    end
    Hreadyin = rdyin; Htrans = trans; Haddr = addr; Hwrite = wr; Hwdata = wd; Prdata = prd;
    #1;
    s_hrd = Hrdata;
    chk("hrdata", s_hrd, prd);
    if (e_wphase[i]) begin
      e_wd[(cyc + 1) % RING] = wd;
      e_wd[(cyc + 2) % RING] = wd;
    end
    acc = rdyin & trans[1] & (addr[31:28] == 4'h8) & e_hrdy[i];
    if (acc) begin
      if (e_wphase[i]) begin
        e_hrdy[(cyc + 2) % RING] = 1'b0;
        sched(cyc + 2, addr, wr);
      end else begin
        sched(cyc, addr, wr);
      end
    end
    clear_slot(i);
    cyc++;
  endtask

  task automatic idle();
    cycle(1'b1, 2'b00, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    Hreset = 1'b1;
    #1;
    chk("rst_pselx", 32'(Pselx), 32'h0);
    chk("rst_penable", 32'(Penable), 32'h0);
    chk("rst_hreadyout", 32'(Hreadyout), 32'h1);
    clear_all();
    @(posedge Hclk);
    #2;
    Hreset = 1'b0;
  endtask

  initial begin
    logic [3:0]  nib;
    int          r;
    clear_all();
    Hreset = 1'b1; Hreadyin = 1'b1; Htrans = 2'b00; Haddr = 32'h0; Hwrite = 1'b0;
    Hwdata = 32'h0; Prdata = 32'h0;
    repeat (2) @(posedge Hclk);
    #2 Hreset = 1'b0;

    // Reset values
    idle();
    chk("reset_paddr", s_paddr, 32'h0);
    chk("reset_pwdata", s_pwd, 32'h0);
    chk("reset_pwrite", 32'(s_pwr), 32'h0);
    chk("reset_hready", 32'(s_hrdy), 32'h1);

    // Single read
    cycle(1'b1, 2'b10, 32'h8000_0010, 1'b0, 32'h0, 32'h0);
    chk("rd_t0_hready", 32'(s_hrdy), 32'h1);
    cycle(1'b1, 2'b00, 32'h0, 1'b0, 32'h0, 32'hDEAD_BEEF);
    chk("rd_t1_psel", 32'(s_psel), 32'h1);
    chk("rd_t1_pen", 32'(s_pen), 32'h0);
    chk("rd_t1_hready", 32'(s_hrdy), 32'h0);
    cycle(1'b1, 2'b00, 32'h0, 1'b0, 32'h0, 32'hDEAD_BEEF);
    chk("rd_t2_psel", 32'(s_psel), 32'h1);
    chk("rd_t2_pen", 32'(s_pen), 32'h1);
    chk("rd_t2_hready", 32'(s_hrdy), 32'h1);
    chk("rd_t2_hrdata", s_hrd, 32'hDEAD_BEEF);
    idle();
    chk("rd_t3_psel", 32'(s_psel), 32'h0);

    // Single write
    cycle(1'b1, 2'b10, 32'h8C00_0004, 1'b1, 32'h0, 32'h0);
    cycle(1'b1, 2'b00, 32'h0, 1'b0, 32'h1234_5678, 32'h0);
    idle();
    chk("wr_t2_psel", 32'(s_psel), 32'h8);
    chk("wr_t2_pen", 32'(s_pen), 32'h0);
    chk("wr_t2_pwrite", 32'(s_pwr), 32'h1);
    chk("wr_t2_pwdata", s_pwd, 32'h1234_5678);
    idle();
    chk("wr_t3_psel", 32'(s_psel), 32'h8);
    chk("wr_t3_pen", 32'(s_pen), 32'h1);
    idle();
    chk("wr_t4_pen", 32'(s_pen), 32'h0);

    // Back-to-back writes
    cycle(1'b1, 2'b10, 32'h8400_0000, 1'b1, 32'h0, 32'h0);
    cycle(1'b1, 2'b10, 32'h8800_0000, 1'b1, 32'hA, 32'h0);
    cycle(1'b1, 2'b00, 32'h0, 1'b0, 32'hB, 32'h0);
    chk("b2b_t2_psel", 32'(s_psel), 32'h2);
    chk("b2b_t2_pwdata", s_pwd, 32'hA);
    cycle(1'b1, 2'b00, 32'h0, 1'b0, 32'hB, 32'h0);
    chk("b2b_t3_pen", 32'(s_pen), 32'h1);
    chk("b2b_t3_hready", 32'(s_hrdy), 32'h0);
    cycle(1'b1, 2'b00, 32'h0, 1'b0, 32'hB, 32'h0);
    chk("b2b_t4_psel", 32'(s_psel), 32'h0);
    chk("b2b_t4_hready", 32'(s_hrdy), 32'h1);
    idle();
    chk("b2b_t5_psel", 32'(s_psel), 32'h4);
    chk("b2b_t5_pwdata", s_pwd, 32'hB);
    chk("b2b_t5_pen", 32'(s_pen), 32'h0);
    idle();
    chk("b2b_t6_pen", 32'(s_pen), 32'h1);
    chk("b2b_t6_hready", 32'(s_hrdy), 32'h1);
    idle();

    // Write followed by pipelined read
    cycle(1'b1, 2'b10, 32'h8000_0004, 1'b1, 32'h0, 32'h0);
    cycle(1'b1, 2'b10, 32'h8000_0020, 1'b0, 32'h55, 32'h0);
    idle();
    idle();
    chk("wr_rd_t3_hready", 32'(s_hrdy), 32'h0);
    chk("wr_rd_t3_pwrite", 32'(s_pwr), 32'h1);
    idle();
    chk("wr_rd_t4_psel", 32'(s_psel), 32'h1);
    chk("wr_rd_t4_pwrite", 32'(s_pwr), 32'h0);
    chk("wr_rd_t4_paddr", s_paddr, 32'h8000_0020);
    cycle(1'b1, 2'b00, 32'h0, 1'b0, 32'h0, 32'hCAFE_F00D);
    chk("wr_rd_t5_pen", 32'(s_pen), 32'h1);
    chk("wr_rd_t5_hready", 32'(s_hrdy), 32'h1);
    chk("wr_rd_t5_hrdata", s_hrd, 32'hCAFE_F00D);
    idle();

    // Out-of-range and IDLE transfers are ignored
    cycle(1'b1, 2'b10, 32'h9000_0000, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 2'b00, 32'h8000_0000, 1'b1, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("ign_psel", 32'(s_psel), 32'h0);
      chk("ign_hready", 32'(s_hrdy), 32'h1);
    end

    // Reset during write ACCESS with a pending write
    cycle(1'b1, 2'b10, 32'h8400_0000, 1'b1, 32'h0, 32'h0);
    cycle(1'b1, 2'b10, 32'h8800_0000, 1'b1, 32'hA, 32'h0);
    idle();
    idle();
    chk("rst_pre_pen", 32'(s_pen), 32'h1);
    chk("rst_pre_hready", 32'(s_hrdy), 32'h0);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      idle();
      chk("rst_post_psel", 32'(s_psel), 32'h0);
    end

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 9));
      nib = (r == 0) ? 4'h9 : (r == 1) ? 4'h0 : 4'h8;
      cycle(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
            {nib, 28'($urandom)}, 1'($urandom_range(0, 1)), $urandom, $urandom);
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
